// File: rtl/banked_prog_rom_pkg.sv
// Shared attributes of the banked program ROM: default geometry, word and
// address types, and the state encodings of the load FSM and the readback
// verify sequencer.
package banked_prog_rom_pkg;

  localparam int N_CORES   = 3;
  localparam int IR_WIDTH  = 16;
  localparam int ROM_DEPTH = 8;
  localparam int AW        = $clog2(ROM_DEPTH);

  typedef logic [IR_WIDTH-1:0] ir_word_t;
  typedef logic [AW-1:0]       rom_addr_t;
  // One extra bit so a full image (ROM_DEPTH words) is representable.
  typedef logic [AW:0]         rom_len_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_WRITE  = 3'd3,
    S_VERIFY = 3'd4,
    S_DONE   = 3'd5
  } prog_state_t;

  typedef enum logic [2:0] {
    V_IDLE  = 3'd0,
    V_SCAN  = 3'd1,
    V_READ  = 3'd2,
    V_DRAIN = 3'd3,
    V_CHECK = 3'd4,
    V_FIN   = 3'd5
  } vseq_state_t;

endpackage

// File: rtl/bank_verify_seq.sv
// Readback verify sequencer. While run is high it walks the masked banks in
// ascending order, reads addresses 0..len-1 of each through port A, sums the
// returned words and compares each bank's sum with ref_sum. done rises once
// all banks are handled; err is set if any masked bank mismatched.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   run               level: sequence while high, return to idle when low
//   mask              banks to check
//   len               number of words per bank to read back
//   ref_sum           expected mod-2^IR_WIDTH sum
//   rd_valid/rd_data  port A readya/douta of every bank
//   rd_en/rd_addr     port A read request per bank, shared address
//   done, err         sequence finished / mismatch seen
module bank_verify_seq #(
  parameter int N_BANKS  = 2,
  parameter int IR_WIDTH = 16,
  parameter int AW       = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              run,
  input  logic [N_BANKS-1:0]                mask,
  input  logic [AW:0]                       len,
  input  logic [IR_WIDTH-1:0]               ref_sum,
  input  logic [N_BANKS-1:0]                rd_valid,
  input  logic [N_BANKS-1:0][IR_WIDTH-1:0]  rd_data,
  output logic [N_BANKS-1:0]                rd_en,
  output logic [AW-1:0]                     rd_addr,
  output logic                              done,
  output logic                              err
);
  import banked_prog_rom_pkg::*;

  localparam int BW = $clog2(N_BANKS + 1);

  vseq_state_t         state_r, state_s;
  logic [BW-1:0]       bank_r, bank_s;
  logic [AW-1:0]       raddr_r, raddr_s;
  logic [IR_WIDTH-1:0] acc_r, acc_s;
  logic                err_r, err_s;
  logic                sel_mask_s, sel_valid_s;
  logic [IR_WIDTH-1:0] sel_data_s;

  // Select mask bit and read-back port of the bank currently being checked.
  always_comb begin
    sel_mask_s  = 1'b0;
    sel_valid_s = 1'b0;
    sel_data_s  = {IR_WIDTH{1'b0}};
    rd_en       = {N_BANKS{1'b0}};
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_r == BW'(b)) begin
        sel_mask_s  = mask[b];
        sel_valid_s = rd_valid[b];
        sel_data_s  = rd_data[b];
        rd_en[b]    = run && (state_r == V_READ);
      end else begin
        rd_en[b]    = 1'b0;
      end
    end
  end

  // Next-state logic: scan for a masked bank, stream reads, drain, compare.
  always_comb begin
    state_s = state_r;
    bank_s  = bank_r;
    raddr_s = raddr_r;
    acc_s   = acc_r;
    err_s   = err_r;
    if (!run) begin
      state_s = V_IDLE;
    end else begin
      case (state_r)
        V_IDLE: begin
          state_s = V_SCAN;
          bank_s  = {BW{1'b0}};
          err_s   = 1'b0;
        end
        V_SCAN: begin
          if (bank_r == BW'(N_BANKS)) begin
            state_s = V_FIN;
          end else if (sel_mask_s) begin
            state_s = (len == {(AW+1){1'b0}}) ? V_CHECK : V_READ;
            raddr_s = {AW{1'b0}};
            acc_s   = {IR_WIDTH{1'b0}};
          end else begin
            bank_s  = bank_r + BW'(1);
          end
        end
        V_READ: begin
          // Data for the previous address returns while the next one issues.
          if (sel_valid_s) begin
            acc_s = acc_r + sel_data_s;
          end else begin
            acc_s = acc_r;
          end
          if ({1'b0, raddr_r} == len - (AW+1)'(1)) begin
            state_s = V_DRAIN;
          end else begin
            raddr_s = raddr_r + AW'(1);
          end
        end
        V_DRAIN: begin
          if (sel_valid_s) begin
            acc_s = acc_r + sel_data_s;
          end else begin
            acc_s = acc_r;
          end
          state_s = V_CHECK;
        end
        V_CHECK: begin
          if (acc_r != ref_sum) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          bank_s  = bank_r + BW'(1);
          state_s = V_SCAN;
        end
        V_FIN: begin
          state_s = V_FIN;
        end
        default: begin
          state_s = V_IDLE;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= V_IDLE;
      bank_r  <= {BW{1'b0}};
      raddr_r <= {AW{1'b0}};
      acc_r   <= {IR_WIDTH{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      bank_r  <= bank_s;
      raddr_r <= raddr_s;
      acc_r   <= acc_s;
      err_r   <= err_s;
    end
  end

  assign rd_addr = raddr_r;
  assign done    = (state_r == V_FIN);
  assign err     = err_r;

endmodule

// File: rtl/dp_bram.sv
// Dual-port block RAM. Port A reads and writes, port B only reads.
// Reads are synchronous: data and its ready flag appear one clock after en.
// Ports:
//   clk, rst_n              clock, async active-low reset (output regs only)
//   ena, wea, addra, dina   port A enable / write enable / address / data in
//   douta, readya           port A read data and read-valid
//   enb, addrb              port B enable / address
//   doutb, readyb           port B read data and read-valid
module dp_bram #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  output logic          readya,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb,
  output logic          readyb
);

  logic [DW-1:0] mem_r [DEPTH];

  // Storage array: written through port A only, never reset.
  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem_r[addra] <= dina;
    end
  end

  // Registered read data and valid flags for both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta  <= {DW{1'b0}};
      doutb  <= {DW{1'b0}};
      readya <= 1'b0;
      readyb <= 1'b0;
    end else begin
      if (ena) begin
        douta <= mem_r[addra];
      end
      if (enb) begin
        doutb <= mem_r[addrb];
      end
      // A write cycle does not produce a read result.
      readya <= ena & ~wea;
      readyb <= enb;
    end
  end

endmodule

// File: rtl/banked_prog_rom.sv
// Multi-bank program ROM. Each dual-port bank feeds two cores for fetch
// (even core on port A, odd core on port B). While prog is high the cores are
// held in reset and the host streams an image over a valid/ready interface;
// every bank selected in p_mask receives the same image through port A.
// Length, running sum, overflow and optional readback verify are reported.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   prog                  programming session level
//   p_mask                banks to write, captured at prog rising edge
//   p_valid/p_ready       host word handshake, p_last marks final word
//   p_data                host word
//   p_len, p_sum          words written / mod-2^IR_WIDTH sum of accepted words
//   p_done, p_overflow    session complete / image longer than ROM_DEPTH
//   p_verify_err          readback sum mismatch in a masked bank
//   active, addr          per-core fetch enable and address
//   d_out, ready          per-core fetched word and its valid
//   core_rst              core reset
module banked_prog_rom #(
  parameter int N_CORES   = banked_prog_rom_pkg::N_CORES,
  parameter int IR_WIDTH  = banked_prog_rom_pkg::IR_WIDTH,
  parameter int ROM_DEPTH = banked_prog_rom_pkg::ROM_DEPTH,
  parameter int VERIFY    = 1,
  localparam int AW       = $clog2(ROM_DEPTH),
  localparam int N_BANKS  = (N_CORES + 1) / 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              prog,
  input  logic [N_BANKS-1:0]                p_mask,
  input  logic                              p_valid,
  input  logic                              p_last,
  input  logic [IR_WIDTH-1:0]               p_data,
  output logic                              p_ready,
  output logic [AW:0]                       p_len,
  output logic [IR_WIDTH-1:0]               p_sum,
  output logic                              p_done,
  output logic                              p_overflow,
  output logic                              p_verify_err,
  input  logic [N_CORES-1:0]                active,
  input  logic [N_CORES-1:0][AW-1:0]        addr,
  output logic [N_CORES-1:0][IR_WIDTH-1:0]  d_out,
  output logic [N_CORES-1:0]                ready,
  output logic                              core_rst
);
  import banked_prog_rom_pkg::*;

  prog_state_t         state_r, state_s;
  logic                prog_q_r;
  logic [N_BANKS-1:0]  mask_r;
  logic [AW:0]         count_r;
  logic [IR_WIDTH-1:0] sum_r;
  logic [IR_WIDTH-1:0] hold_r;
  logic                hold_last_r;
  logic                overflow_r, verr_r, done_r;

  logic rise_s, ready_s, accept_s, write_s, done_set_s, ovf_set_s;
  logic vrun_s, vdone_s, verr_s;

  logic [N_BANKS-1:0]                ena_s, wea_s, enb_s, readya_s, readyb_s;
  logic [N_BANKS-1:0][AW-1:0]        addra_s, addrb_s;
  logic [N_BANKS-1:0][IR_WIDTH-1:0]  dina_s, douta_s, doutb_s;
  logic [N_BANKS-1:0]                vs_en_s;
  logic [AW-1:0]                     vs_addr_s;

  assign rise_s   = prog & ~prog_q_r;
  // Gated by the live prog level so nothing is accepted or written once the
  // host has dropped prog, even in the cycle before the FSM returns to idle.
  assign ready_s  = (state_r == S_LOAD) && prog && (count_r < (AW+1)'(ROM_DEPTH));
  assign accept_s = p_valid & ready_s;
  assign write_s  = (state_r == S_WRITE) && prog;
  assign vrun_s   = (state_r == S_VERIFY) && prog;

  // Load FSM next-state logic.
  always_comb begin
    state_s    = state_r;
    done_set_s = 1'b0;
    ovf_set_s  = 1'b0;
    if (rise_s) begin
      state_s = S_CLEAR;
    end else if (!prog) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_s = S_IDLE;
        S_CLEAR: state_s = S_LOAD;
        S_LOAD: begin
          if (accept_s) begin
            state_s = S_WRITE;
          end else begin
            state_s = S_LOAD;
          end
        end
        S_WRITE: begin
          if (hold_last_r) begin
            if (VERIFY != 0) begin
              state_s = S_VERIFY;
            end else begin
              state_s    = S_DONE;
              done_set_s = 1'b1;
            end
          end else if (count_r + (AW+1)'(1) == (AW+1)'(ROM_DEPTH)) begin
            state_s    = S_DONE;
            done_set_s = 1'b1;
            ovf_set_s  = 1'b1;
          end else begin
            state_s = S_LOAD;
          end
        end
        S_VERIFY: begin
          if (vdone_s) begin
            state_s    = S_DONE;
            done_set_s = 1'b1;
          end else begin
            state_s = S_VERIFY;
          end
        end
        S_DONE:  state_s = S_DONE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Session state, counters and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      prog_q_r    <= 1'b0;
      mask_r      <= {N_BANKS{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      sum_r       <= {IR_WIDTH{1'b0}};
      hold_r      <= {IR_WIDTH{1'b0}};
      hold_last_r <= 1'b0;
      overflow_r  <= 1'b0;
      verr_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r  <= state_s;
      prog_q_r <= prog;
      if (rise_s) begin
        mask_r      <= p_mask;
        count_r     <= {(AW+1){1'b0}};
        sum_r       <= {IR_WIDTH{1'b0}};
        hold_last_r <= 1'b0;
        overflow_r  <= 1'b0;
        verr_r      <= 1'b0;
        done_r      <= 1'b0;
      end else begin
        if (accept_s) begin
          sum_r       <= sum_r + p_data;
          hold_r      <= p_data;
          hold_last_r <= p_last;
        end
        if (write_s) begin
          count_r <= count_r + (AW+1)'(1);
        end
        if (ovf_set_s) begin
          overflow_r <= 1'b1;
        end
        if (done_set_s) begin
          done_r <= 1'b1;
        end
        if (vrun_s && vdone_s) begin
          verr_r <= verr_r | verr_s;
        end
      end
    end
  end

  // Port A steering: fetch for the even core, or load writes / verify reads.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      ena_s[b]   = 1'b0;
      wea_s[b]   = 1'b0;
      addra_s[b] = {AW{1'b0}};
      dina_s[b]  = hold_r;
      if (prog_q_r) begin
        if (write_s) begin
          ena_s[b]   = mask_r[b];
          wea_s[b]   = mask_r[b];
          addra_s[b] = count_r[AW-1:0];
        end else if (state_r == S_VERIFY) begin
          ena_s[b]   = vs_en_s[b];
          addra_s[b] = vs_addr_s;
        end else begin
          ena_s[b]   = 1'b0;
        end
      end else begin
        ena_s[b]   = active[2*b];
        addra_s[b] = addr[2*b];
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    // Port B serves the odd core; the last bank's port B is idle when
    // N_CORES is odd.
    if (2*b + 1 < N_CORES) begin : g_pb
      assign enb_s[b]   = ~prog_q_r & active[2*b+1];
      assign addrb_s[b] = prog_q_r ? {AW{1'b0}} : addr[2*b+1];
    end else begin : g_nopb
      assign enb_s[b]   = 1'b0;
      assign addrb_s[b] = {AW{1'b0}};
    end

    dp_bram #(
      .DW    (IR_WIDTH),
      .DEPTH (ROM_DEPTH),
      .AW    (AW)
    ) u_bram (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena_s[b]),
      .wea    (wea_s[b]),
      .addra  (addra_s[b]),
      .dina   (dina_s[b]),
      .douta  (douta_s[b]),
      .readya (readya_s[b]),
      .enb    (enb_s[b]),
      .addrb  (addrb_s[b]),
      .doutb  (doutb_s[b]),
      .readyb (readyb_s[b])
    );
  end

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    if (i % 2 == 0) begin : g_even
      assign d_out[i] = douta_s[i/2];
      assign ready[i] = readya_s[i/2];
    end else begin : g_odd
      assign d_out[i] = doutb_s[i/2];
      assign ready[i] = readyb_s[i/2];
    end
  end

  if (VERIFY != 0) begin : g_verify
    bank_verify_seq #(
      .N_BANKS  (N_BANKS),
      .IR_WIDTH (IR_WIDTH),
      .AW       (AW)
    ) u_verify (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (vrun_s),
      .mask     (mask_r),
      .len      (count_r),
      .ref_sum  (sum_r),
      .rd_valid (readya_s),
      .rd_data  (douta_s),
      .rd_en    (vs_en_s),
      .rd_addr  (vs_addr_s),
      .done     (vdone_s),
      .err      (verr_s)
    );
  end else begin : g_noverify
    assign vs_en_s   = {N_BANKS{1'b0}};
    assign vs_addr_s = {AW{1'b0}};
    assign vdone_s   = 1'b1;
    assign verr_s    = 1'b0;
  end

  assign p_ready      = ready_s;
  assign p_len        = count_r;
  assign p_sum        = sum_r;
  assign p_done       = done_r;
  assign p_overflow   = overflow_r;
  assign p_verify_err = verr_r;
  // Cores stay in reset during chip reset and for the whole session.
  assign core_rst     = ~rst_n | prog_q_r;

endmodule

// File: tb/tb_banked_prog_rom.sv
module tb_banked_prog_rom;
  import banked_prog_rom_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, prog, p_valid, p_last;
  logic [1:0]        p_mask;
  logic [15:0]       p_data;
  logic              p_ready, p_done, p_overflow, p_verify_err, core_rst;
  logic [3:0]        p_len;
  logic [15:0]       p_sum;
  logic [2:0]        active, ready;
  logic [2:0][2:0]   addr;
  logic [2:0][15:0]  d_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_prog_rom #(
    .N_CORES(3), .IR_WIDTH(16), .ROM_DEPTH(8), .VERIFY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prog(prog), .p_mask(p_mask),
    .p_valid(p_valid), .p_last(p_last), .p_data(p_data), .p_ready(p_ready),
    .p_len(p_len), .p_sum(p_sum), .p_done(p_done), .p_overflow(p_overflow),
    .p_verify_err(p_verify_err), .active(active), .addr(addr),
    .d_out(d_out), .ready(ready), .core_rst(core_rst)
  );

  task automatic start_session(input logic [1:0] m);
    p_mask = m;
    prog   = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] d, input logic l, output bit ok);
    ok = 1'b0;
    p_valid = 1'b1; p_data = d; p_last = l;
    for (int k = 0; k < 20; k++) begin
      if (p_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    p_valid = 1'b0; p_last = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (p_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic end_session();
    prog = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL reset_p_ready: got %b want 0", p_ready); end
    checks++; if ({p_done, p_overflow, p_verify_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {p_done, p_overflow, p_verify_err}); end
    checks++; if (p_len !== 4'd0) begin errors++; $display("FAIL reset_p_len: got %0d want 0", p_len); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL reset_release_core_rst: got %b want 0", core_rst); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    start_session(2'b11);
    send_word(16'h0055, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midwr_accept: got %b want 1", ok); end
    checks++; if (dut.state_r !== S_WRITE) begin errors++; $display("FAIL midwr_in_write: got %0d want %0d", dut.state_r, S_WRITE); end
    rst_n = 1'b0;
    #1;
    checks++; if (dut.state_r !== S_IDLE) begin errors++; $display("FAIL midwr_state: got %0d want %0d", dut.state_r, S_IDLE); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL midwr_core_rst: got %b want 1", core_rst); end
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL midwr_p_ready: got %b want 0", p_ready); end
    checks++; if (p_sum !== 16'h0000) begin errors++; $display("FAIL midwr_p_sum: got %h want 0000", p_sum); end
    checks++; if ({p_done, p_overflow, p_verify_err, p_len} !== 7'd0) begin errors++; $display("FAIL midwr_flags: got %b want 0", {p_done, p_overflow, p_verify_err, p_len}); end
    @(negedge clk);
    prog  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    bit ok, all_ok;
    logic [15:0] words [3];
    words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
    all_ok = 1'b1;
    start_session(2'b11);
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], (i == 2), ok);
      all_ok &= ok;
    end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", all_ok); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_timeout: got %b want 1", ok); end
    checks++; if (p_len !== 4'd3) begin errors++; $display("FAIL basic_p_len: got %0d want 3", p_len); end
    checks++; if (p_sum !== 16'h0066) begin errors++; $display("FAIL basic_p_sum: got %h want 0066", p_sum); end
    checks++; if ({p_overflow, p_verify_err} !== 2'b00) begin errors++; $display("FAIL basic_clean_flags: got %b want 00", {p_overflow, p_verify_err}); end
    prog = 1'b0;
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL basic_core_rst_hold: got %b want 1", core_rst); end
    @(negedge clk);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL basic_core_rst_release: got %b want 0", core_rst); end
    active = 3'b111;
    addr[0] = 3'd2; addr[1] = 3'd2; addr[2] = 3'd2;
    @(negedge clk);
    checks++; if (ready !== 3'b111) begin errors++; $display("FAIL basic_ready: got %b want 111", ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (d_out[i] !== 16'h0033) begin errors++; $display("FAIL basic_fetch_core%0d: got %h want 0033", i, d_out[i]); end
    end
    addr[1] = 3'd0;
    @(negedge clk);
    checks++; if (d_out[1] !== 16'h0011) begin errors++; $display("FAIL basic_fetch_b0: got %h want 0011", d_out[1]); end
    active = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_mask();
    bit ok;
    start_session(2'b01);
    for (int i = 0; i < 4; i++) send_word(16'h00A0 + 16'(i), (i == 3), ok);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mask_done_timeout: got %b want 1", ok); end
    checks++; if (p_len !== 4'd4) begin errors++; $display("FAIL mask_p_len: got %0d want 4", p_len); end
    checks++; if (p_sum !== 16'h0286) begin errors++; $display("FAIL mask_p_sum: got %h want 0286", p_sum); end
    checks++; if (p_verify_err !== 1'b0) begin errors++; $display("FAIL mask_verify: got %b want 0", p_verify_err); end
    end_session();
    active = 3'b111;
    addr[0] = 3'd2; addr[1] = 3'd3; addr[2] = 3'd0;
    @(negedge clk);
    checks++; if (d_out[0] !== 16'h00A2) begin errors++; $display("FAIL mask_core0: got %h want 00a2", d_out[0]); end
    checks++; if (d_out[1] !== 16'h00A3) begin errors++; $display("FAIL mask_core1: got %h want 00a3", d_out[1]); end
    checks++; if (d_out[2] !== 16'h0011) begin errors++; $display("FAIL mask_core2_a0: got %h want 0011", d_out[2]); end
    addr[2] = 3'd2;
    @(negedge clk);
    checks++; if (d_out[2] !== 16'h0033) begin errors++; $display("FAIL mask_core2_a2: got %h want 0033", d_out[2]); end
    active = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    all_ok = 1'b1;
    start_session(2'b11);
    for (int i = 0; i < 8; i++) begin
      send_word(16'h0100 + 16'(i), 1'b0, ok);
      all_ok &= ok;
    end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL ovf_first8_accept: got %b want 1", all_ok); end
    send_word(16'h0108, 1'b0, ok);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL ovf_ninth_accept: got %b want 0", ok); end
    checks++; if (p_len !== 4'd8) begin errors++; $display("FAIL ovf_p_len: got %0d want 8", p_len); end
    checks++; if ({p_overflow, p_done, p_ready} !== 3'b110) begin errors++; $display("FAIL ovf_flags: got %b want 110", {p_overflow, p_done, p_ready}); end
    checks++; if (p_sum !== 16'h081C) begin errors++; $display("FAIL ovf_p_sum: got %h want 081c", p_sum); end
    end_session();
  endtask

  task automatic test_verify_fault();
    bit ok, seen;
    start_session(2'b01);
    send_word(16'h0005, 1'b0, ok);
    send_word(16'h0006, 1'b1, ok);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (dut.state_r == S_VERIFY) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL vfy_reach_verify: got %b want 1", seen); end
    force dut.g_bank[0].u_bram.douta = 16'h0F0F;
    wait_done(ok);
    release dut.g_bank[0].u_bram.douta;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL vfy_done_timeout: got %b want 1", ok); end
    checks++; if (p_verify_err !== 1'b1) begin errors++; $display("FAIL vfy_err: got %b want 1", p_verify_err); end
    checks++; if (p_sum !== 16'h000B) begin errors++; $display("FAIL vfy_p_sum: got %h want 000b", p_sum); end
    end_session();
  endtask

  task automatic test_abort();
    bit ok;
    start_session(2'b11);
    send_word(16'h0007, 1'b0, ok);
    send_word(16'h0008, 1'b0, ok);
    @(negedge clk);
    prog = 1'b0;
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL abort_core_rst_hold: got %b want 1", core_rst); end
    @(negedge clk);
    checks++; if (dut.state_r !== S_IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", dut.state_r, S_IDLE); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL abort_core_rst: got %b want 0", core_rst); end
    checks++; if (p_done !== 1'b0) begin errors++; $display("FAIL abort_p_done: got %b want 0", p_done); end
    checks++; if (p_len !== 4'd2) begin errors++; $display("FAIL abort_p_len: got %0d want 2", p_len); end
    checks++; if (p_sum !== 16'h000F) begin errors++; $display("FAIL abort_p_sum: got %h want 000f", p_sum); end
    p_valid = 1'b1; p_data = 16'h0099;
    repeat (3) @(negedge clk);
    checks++; if ({p_ready, p_len} !== 5'b0_0010) begin errors++; $display("FAIL idle_ignore: got %b want 00010", {p_ready, p_len}); end
    p_valid = 1'b0;
    start_session(2'b11);
    checks++; if ({p_len, p_sum} !== 20'd0) begin errors++; $display("FAIL rise_clear: got %h want 0", {p_len, p_sum}); end
    end_session();
  endtask

  initial begin
    rst_n = 1'b0; prog = 1'b0; p_mask = 2'b00;
    p_valid = 1'b0; p_last = 1'b0; p_data = 16'h0000;
    active = 3'b000; addr = '0;
    test_reset();
    test_reset_mid_write();
    test_load_basic();
    test_mask();
    test_overflow();
    test_verify_fault();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
